// File: rtl/avlst_pkg.sv
// rtl/avlst_pkg.sv - shared types, defaults and width helper for the round-robin arbiter
package avlst_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int DEF_K         = 4;
  localparam int DEF_DATA_W    = 128;
  localparam int DEF_MAX_BURST = 4;

  // Bits needed to index 'value' distinct items (ceil(log2(value))).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/avlst_rr_arbiter_if.sv
// rtl/avlst_rr_arbiter_if.sv - K-source input and single tagged output stream bundle
interface avlst_rr_arbiter_if
  import avlst_pkg::*;
#(
  parameter int K      = DEF_K,
  parameter int DATA_W = DEF_DATA_W
) ();

  localparam int CH_W = clog2(K);

  logic [K-1:0]        asi_valid;
  logic [K*DATA_W-1:0] asi_data;
  logic [K-1:0]        asi_ready;
  logic                aso_valid;
  logic [DATA_W-1:0]   aso_data;
  logic [CH_W-1:0]     aso_channel;
  logic                aso_ready;

  // Arbiter side: consumes the K sources, produces the shared stream.
  modport slave (
    input  asi_valid, asi_data, aso_ready,
    output asi_ready, aso_valid, aso_data, aso_channel
  );

  // Environment side: the sources and the downstream consumer.
  modport master (
    output asi_valid, asi_data, aso_ready,
    input  asi_ready, aso_valid, aso_data, aso_channel
  );

endinterface

// File: rtl/avlst_rr_pick.sv
// rtl/avlst_rr_pick.sv - combinational round-robin picker starting after the last grant
module avlst_rr_pick
  import avlst_pkg::*;
#(
  parameter int K = DEF_K
) (
  input  logic [K-1:0]          req,
  input  logic [clog2(K)-1:0]   last,
  output logic                  any,
  output logic [clog2(K)-1:0]   idx
);

  localparam int CH_W = clog2(K);

  logic [2*K-1:0] req2;
  logic [K-1:0]   rot;

  // Rotate so that bit 0 is the source after 'last', then take the lowest set bit.
  always_comb begin
    req2 = {req, req};
    rot  = K'(req2 >> (int'(last) + 1));
    any  = |req;
    idx  = '0;
    for (int i = K - 1; i >= 0; i--) begin
      if (rot[i]) begin
        idx = CH_W'((int'(last) + 1 + i) % K);
      end
    end
  end

endmodule

// File: rtl/avlst_rr_arbiter.sv
// rtl/avlst_rr_arbiter.sv - round-robin burst arbiter with a registered, channel-tagged output
module avlst_rr_arbiter
  import avlst_pkg::*;
#(
  parameter int K         = DEF_K,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic               csi_clk,
  input  logic               rsi_reset,
  avlst_rr_arbiter_if.slave  bus
);

  localparam int CH_W = clog2(K);
  localparam int BC_W = clog2(MAX_BURST + 1);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     last_q, last_d;
  logic [BC_W-1:0]     burst_q, burst_d;
  logic                aso_valid_q, aso_valid_d;
  logic [DATA_W-1:0]   aso_data_q, aso_data_d;
  logic [CH_W-1:0]     aso_ch_q, aso_ch_d;

  logic                pick_any;
  logic [CH_W-1:0]     pick_idx;
  logic                out_free;
  logic                xfer;
  logic [K-1:0]        ready_vec;
  logic [BC_W-1:0]     burst_inc;

  avlst_rr_pick #(.K(K)) u_pick (
    .req  (bus.asi_valid),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign out_free  = ~aso_valid_q | bus.aso_ready;
  assign xfer      = (state_q == GRANT) & out_free & bus.asi_valid[last_q];
  assign burst_inc = BC_W'(burst_q + 1'b1);

  // Only the granted source sees ready, and only while the output stage can take a word.
  always_comb begin
    ready_vec = '0;
    if ((state_q == GRANT) && out_free) begin
      ready_vec[last_q] = 1'b1;
    end
  end

  assign bus.asi_ready   = ready_vec;
  assign bus.aso_valid   = aso_valid_q;
  assign bus.aso_data    = aso_data_q;
  assign bus.aso_channel = aso_ch_q;

  // Next state: arbitration in IDLE, burst accounting and release in GRANT, output stage load/drain.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    burst_d     = burst_q;
    aso_valid_d = aso_valid_q;
    aso_data_d  = aso_data_q;
    aso_ch_d    = aso_ch_q;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          last_d  = pick_idx;
          burst_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!bus.asi_valid[last_q]) begin
          state_d = IDLE;
        end else if (out_free) begin
          burst_d = burst_inc;
          if (burst_inc == BC_W'(MAX_BURST)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (xfer) begin
      aso_valid_d = 1'b1;
      aso_data_d  = bus.asi_data[last_q*DATA_W +: DATA_W];
      aso_ch_d    = last_q;
    end else if (out_free) begin
      aso_valid_d = 1'b0;
    end
  end

  // State and output registers; last grant resets to K-1 so source 0 wins first.
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      state_q     <= IDLE;
      last_q      <= CH_W'(K - 1);
      burst_q     <= '0;
      aso_valid_q <= 1'b0;
      aso_data_q  <= '0;
      aso_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      burst_q     <= burst_d;
      aso_valid_q <= aso_valid_d;
      aso_data_q  <= aso_data_d;
      aso_ch_q    <= aso_ch_d;
    end
  end

endmodule

// File: tb/tb_avlst_rr_arbiter.sv
// tb/tb_avlst_rr_arbiter.sv - directed self-checking bench for the round-robin arbiter
module tb_avlst_rr_arbiter;
  import avlst_pkg::*;

  localparam int K  = 4;
  localparam int DW = 128;
  localparam int MB = 4;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst2 = 1'b1;

  always #5 clk = ~clk;

  avlst_rr_arbiter_if #(.K(K), .DATA_W(DW)) bus ();
  avlst_rr_arbiter #(.K(K), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .csi_clk   (clk),
    .rsi_reset (rst),
    .bus       (bus)
  );

  avlst_rr_arbiter_if #(.K(2), .DATA_W(DW)) bus2 ();
  avlst_rr_arbiter #(.K(2), .DATA_W(DW), .MAX_BURST(1)) dut2 (
    .csi_clk   (clk),
    .rsi_reset (rst2),
    .bus       (bus2)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [K][16];
  int            head [K];
  int            cnt  [K];

  int            cyc;
  int            n_out;
  int            n_acc;
  logic [DW-1:0] out_data [64];
  int            out_ch   [64];
  int            out_cyc  [64];
  int            acc_cyc  [64];
  logic [K-1:0]  rdy_tr   [128];

  logic          samp_valid;
  logic [DW-1:0] samp_data;
  int            samp_ch;
  logic [K-1:0]  samp_ready;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < K; i++) begin
      if (head[i] < cnt[i]) begin
        bus.asi_valid[i]          = 1'b1;
        bus.asi_data[i*DW +: DW]  = mem[i][head[i]];
      end else begin
        bus.asi_valid[i]          = 1'b0;
        bus.asi_data[i*DW +: DW]  = '0;
      end
    end
  endtask

  task automatic load(input int src, input int n, input logic [DW-1:0] base);
    for (int j = 0; j < n; j++) mem[src][j] = base + DW'(j);
    head[src] = 0;
    cnt[src]  = n;
  endtask

  // One clock: sample at the falling edge, advance the source model just after the rising edge.
  task automatic step();
    logic [K-1:0] acc;
    @(negedge clk);
    acc        = bus.asi_valid & bus.asi_ready;
    samp_valid = bus.aso_valid;
    samp_data  = bus.aso_data;
    samp_ch    = int'(bus.aso_channel);
    samp_ready = bus.asi_ready;
    if (cyc < 128) rdy_tr[cyc] = bus.asi_ready;
    for (int i = 0; i < K; i++) begin
      if (acc[i] && n_acc < 64) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
    end
    if (bus.aso_valid && bus.aso_ready && n_out < 64) begin
      out_data[n_out] = bus.aso_data;
      out_ch[n_out]   = int'(bus.aso_channel);
      out_cyc[n_out]  = cyc;
      n_out++;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < K; i++) if (acc[i]) head[i]++;
    drive();
  endtask

  task automatic clear_log();
    cyc   = 0;
    n_out = 0;
    n_acc = 0;
  endtask

  task automatic reset_all();
    rst = 1'b1;
    for (int i = 0; i < K; i++) begin
      head[i] = 0;
      cnt[i]  = 0;
    end
    drive();
    bus.aso_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_log();
  endtask

  int            n6;
  int            ch6  [8];
  int            cy6  [8];
  logic [DW-1:0] dat6 [8];
  int            guard;

  initial begin
    bus.asi_valid  = '0;
    bus.asi_data   = '0;
    bus.aso_ready  = 1'b1;
    bus2.asi_valid = '0;
    bus2.asi_data  = '0;
    bus2.aso_ready = 1'b1;
    for (int i = 0; i < K; i++) begin
      head[i] = 0;
      cnt[i]  = 0;
    end
    clear_log();

    // Reset values
    #2;
    check("rst_aso_valid", bus.aso_valid, 0);
    check("rst_aso_data", bus.aso_data, 0);
    check("rst_aso_channel", bus.aso_channel, 0);
    check("rst_asi_ready", bus.asi_ready, 0);

    // 1: lone source 2, six words, burst of 4 then bubble then 2
    reset_all();
    load(2, 6, 128'hA0);
    drive();
    repeat (20) step();
    check("t1_count", n_out, 6);
    for (int k = 0; k < 6; k++) begin
      check("t1_data", out_data[k], 128'hA0 + DW'(k));
      check("t1_chan", out_ch[k], 2);
    end
    check("t1_first_accept", acc_cyc[0], 1);
    check("t1_latency", out_cyc[0] - acc_cyc[0], 1);
    check("t1_burst_span", acc_cyc[3] - acc_cyc[0], 3);
    check("t1_bubble_gap", acc_cyc[4] - acc_cyc[3], 2);
    check("t1_bubble_ready", rdy_tr[acc_cyc[3] + 1], 0);
    check("t1_out_gap", out_cyc[4] - out_cyc[3], 2);

    // 2: all sources busy, order 0,1,2,3,0 in bursts of 4
    reset_all();
    for (int i = 0; i < K; i++) load(i, 8, DW'((i + 1) * 256));
    drive();
    repeat (40) step();
    check("t2_enough", n_out >= 20, 1);
    for (int k = 0; k < 20; k++) check("t2_chan_seq", out_ch[k], (k / 4) % 4);
    check("t2_grant_gap", acc_cyc[4] - acc_cyc[3], 2);
    check("t2_wrap_data", out_data[16], 128'h104);

    // 3: backpressure for 5 cycles mid-burst
    reset_all();
    load(0, 6, 128'hC0);
    drive();
    guard = 0;
    while (n_out < 1 && guard < 20) begin
      step();
      guard++;
    end
    check("t3_first_out", n_out, 1);
    bus.aso_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      step();
      check("t3_hold_valid", samp_valid, 1);
      check("t3_hold_data", samp_data, 128'hC1);
      check("t3_hold_chan", samp_ch, 0);
      check("t3_hold_ready", samp_ready, 0);
    end
    bus.aso_ready = 1'b1;
    repeat (15) step();
    check("t3_count", n_out, 6);
    for (int k = 0; k < 6; k++) check("t3_data", out_data[k], 128'hC0 + DW'(k));
    check("t3_stall_gap", acc_cyc[2] - acc_cyc[1], 6);
    check("t3_resume_gap", acc_cyc[3] - acc_cyc[2], 1);
    check("t3_burst_end_gap", acc_cyc[4] - acc_cyc[3], 2);

    // 4: source 1 releases early after 2 words, then source 3
    reset_all();
    load(1, 2, 128'h10);
    load(3, 4, 128'h30);
    drive();
    repeat (20) step();
    check("t4_count", n_out, 6);
    check("t4_chan0", out_ch[0], 1);
    check("t4_chan1", out_ch[1], 1);
    for (int k = 2; k < 6; k++) check("t4_chan3", out_ch[k], 3);
    check("t4_data_first3", out_data[2], 128'h30);

    // 5: asynchronous reset after the second word of source 1
    reset_all();
    load(1, 8, 128'h50);
    load(2, 8, 128'h60);
    drive();
    guard = 0;
    while (n_acc < 2 && guard < 20) begin
      step();
      guard++;
    end
    check("t5_two_accepted", n_acc, 2);
    check("t5_pre_valid", bus.aso_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_valid", bus.aso_valid, 0);
    check("t5_async_ready", bus.asi_ready, 0);
    check("t5_async_data", bus.aso_data, 0);
    step();
    rst = 1'b0;
    clear_log();
    repeat (10) step();
    check("t5_first_chan", out_ch[0], 1);
    check("t5_first_data", out_data[0], 128'h52);
    #2;
    rst = 1'b1;
    load(0, 4, 128'h70);
    step();
    rst = 1'b0;
    clear_log();
    drive();
    repeat (10) step();
    check("t5_src0_first", out_ch[0], 0);
    check("t5_src0_data", out_data[0], 128'h70);

    // 6: MAX_BURST=1, two sources always valid
    bus2.asi_valid = 2'b11;
    bus2.asi_data  = {128'h201, 128'h100};
    bus2.aso_ready = 1'b1;
    @(posedge clk);
    #1;
    rst2 = 1'b0;
    n6 = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (bus2.aso_valid && n6 < 8) begin
        ch6[n6]  = int'(bus2.aso_channel);
        cy6[n6]  = c;
        dat6[n6] = bus2.aso_data;
        n6++;
      end
    end
    check("t6_enough", n6 >= 4, 1);
    for (int k = 0; k < 4; k++) begin
      check("t6_chan_alt", ch6[k], k % 2);
      check("t6_data", dat6[k], (k % 2 == 1) ? 128'h201 : 128'h100);
    end
    for (int k = 0; k < 3; k++) check("t6_gap", cy6[k + 1] - cy6[k], 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
